// File: rtl/lcg_pkg.sv
// lcg_pkg: shared constants, FSM encoding and helpers for the LCG seed-range scanner.
//   LCG_W / LCG_LANES / LCG_LAT : default seed width, lane count, lane latency
//   lcg_state_e                 : scan controller state encoding
//   idx_width()                 : bit width needed to index n lanes (minimum 1)
package lcg_pkg;

   localparam int unsigned LCG_W     = 32;
   localparam int unsigned LCG_LANES = 4;
   localparam int unsigned LCG_LAT   = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } lcg_state_e;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lcg_scan_pipe.sv
// lcg_scan_pipe: LAT-deep delay line of issued batches (base seed + lane-valid
// mask) so returning lane hits can be matched back to the seeds that caused them.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_flush        : clear every stage (abort)
//   i_base, i_mask : batch presented on the lane outputs this cycle
//   o_base, o_mask : batch issued LAT cycles ago, aligned with lane hits
//   o_empty_c      : no valid batch held in any stage
module lcg_scan_pipe
   import lcg_pkg::*;
#(
   parameter int unsigned W     = LCG_W,
   parameter int unsigned LANES = LCG_LANES,
   parameter int unsigned LAT   = LCG_LAT
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic [W-1:0]     i_base,
   input  logic [LANES-1:0] i_mask,
   output logic [W-1:0]     o_base,
   output logic [LANES-1:0] o_mask,
   output logic             o_empty_c
);

   logic [W-1:0]     r_base [LAT];
   logic [LANES-1:0] r_mask [LAT];

   // Shift register; stage 0 captures the batch currently on the lane outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         for (int s = 0; s < int'(LAT); s++) begin
            r_base[s] <= '0;
            r_mask[s] <= '0;
         end
      end else begin
         r_base[0] <= i_base;
         r_mask[0] <= i_mask;
         for (int s = 1; s < int'(LAT); s++) begin
            r_base[s] <= r_base[s-1];
            r_mask[s] <= r_mask[s-1];
         end
      end
   end

   // Empty when no stage carries a valid lane.
   always_comb begin
      o_empty_c = 1'b1;
      for (int s = 0; s < int'(LAT); s++) begin
         if (|r_mask[s]) o_empty_c = 1'b0;
      end
   end

   assign o_base = r_base[LAT-1];
   assign o_mask = r_mask[LAT-1];

endmodule

// File: rtl/lcg_scan_ctrl.sv
// lcg_scan_ctrl: sweeps an inclusive seed range [seed_lo, seed_hi] across LANES
// parallel checker lanes and reports the lowest seed whose lane signals a hit.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_start          : begin a scan (accepted in IDLE or DONE)
//   i_seed_lo/hi     : inclusive range, sampled on an accepted start
//   i_abort          : only with LCG_SCAN_ABORT_EN defined; ends a scan, found=0
//   o_lane_seed      : per-lane candidate, lane i at [i*W +: W]
//   o_lane_valid     : per-lane issue strobe
//   i_lane_hit       : per-lane result, LAT cycles after the matching strobe
//   o_busy / o_done  : scanning-or-draining / finished (level)
//   o_found          : a hit was recorded (valid while done)
//   o_found_seed     : lowest matching seed (valid while done and found)
module lcg_scan_ctrl
   import lcg_pkg::*;
#(
   parameter int unsigned W     = LCG_W,
   parameter int unsigned LANES = LCG_LANES,
   parameter int unsigned LAT   = LCG_LAT
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [W-1:0]       i_seed_lo,
   input  logic [W-1:0]       i_seed_hi,
`ifdef LCG_SCAN_ABORT_EN
   input  logic               i_abort,
`endif
   output logic [LANES*W-1:0] o_lane_seed,
   output logic [LANES-1:0]   o_lane_valid,
   input  logic [LANES-1:0]   i_lane_hit,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_found,
   output logic [W-1:0]       o_found_seed
);

   localparam int unsigned PW = W + 1;
   localparam int unsigned IW = idx_width(LANES);

   lcg_state_e         r_state, w_state_nxt;
   logic [W:0]         r_ptr, w_ptr_nxt;
   logic [W-1:0]       r_seed_hi, w_seed_hi_nxt;
   logic [LANES*W-1:0] r_lane_seed, w_lane_seed_nxt;
   logic [LANES-1:0]   r_lane_valid, w_lane_valid_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_done, w_done_nxt;
   logic               r_found, w_found_nxt;
   logic [W-1:0]       r_found_seed, w_found_seed_nxt;

   logic               w_issue;
   logic [W:0]         w_issue_ptr;
   logic [W-1:0]       w_issue_hi;
   logic               w_flush;
   logic               w_active;
   logic [W-1:0]       w_pipe_base;
   logic [LANES-1:0]   w_pipe_mask;
   logic               w_pipe_empty;
   logic [LANES-1:0]   w_hit_mask;
   logic               w_hit_any;
   logic [IW-1:0]      w_hit_idx;

   // In-flight batches, fed from the registered lane outputs.
   lcg_scan_pipe #(
      .W     (W),
      .LANES (LANES),
      .LAT   (LAT)
   ) u_pipe (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_flush   (w_flush),
      .i_base    (r_lane_seed[W-1:0]),
      .i_mask    (r_lane_valid),
      .o_base    (w_pipe_base),
      .o_mask    (w_pipe_mask),
      .o_empty_c (w_pipe_empty)
   );

   // Hits count only for lanes actually issued, and only while a scan is live.
   assign w_active   = (r_state == ST_SCAN) || (r_state == ST_DRAIN);
   assign w_hit_mask = i_lane_hit & w_pipe_mask & {LANES{w_active}};
   assign w_hit_any  = |w_hit_mask;

   // Lowest hitting lane wins within a batch.
   always_comb begin
      w_hit_idx = '0;
      for (int i = int'(LANES) - 1; i >= 0; i--) begin
         if (w_hit_mask[i]) w_hit_idx = IW'(i);
      end
   end

   // Next-state, issue and result logic.
   always_comb begin
      w_state_nxt      = r_state;
      w_ptr_nxt        = r_ptr;
      w_seed_hi_nxt    = r_seed_hi;
      w_found_nxt      = r_found;
      w_found_seed_nxt = r_found_seed;
      w_lane_seed_nxt  = r_lane_seed;
      w_lane_valid_nxt = '0;
      w_issue          = 1'b0;
      w_issue_ptr      = r_ptr;
      w_issue_hi       = r_seed_hi;
      w_flush          = 1'b0;
      w_busy_nxt       = 1'b0;
      w_done_nxt       = 1'b0;

      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (i_start) begin
               w_found_nxt      = 1'b0;
               w_found_seed_nxt = '0;
               w_seed_hi_nxt    = i_seed_hi;
               if (i_seed_lo <= i_seed_hi) begin
                  w_state_nxt = ST_SCAN;
                  w_issue     = 1'b1;
                  w_issue_ptr = {1'b0, i_seed_lo};
                  w_issue_hi  = i_seed_hi;
               end else begin
                  w_state_nxt = ST_DONE;
               end
            end
         end
         ST_SCAN: begin
            // r_ptr already points past the batch on the outputs; beyond hi
            // means that batch contained the last seed.
            if (w_hit_any) begin
               w_found_nxt      = 1'b1;
               w_found_seed_nxt = w_pipe_base + W'(w_hit_idx);
               w_state_nxt      = ST_DRAIN;
            end else if (r_ptr > PW'(r_seed_hi)) begin
               w_state_nxt = ST_DRAIN;
            end else begin
               w_issue = 1'b1;
            end
         end
         ST_DRAIN: begin
            // Batches return in issue order, so the first hit is the lowest.
            if (w_hit_any && !r_found) begin
               w_found_nxt      = 1'b1;
               w_found_seed_nxt = w_pipe_base + W'(w_hit_idx);
            end
            if (w_pipe_empty) w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase

`ifdef LCG_SCAN_ABORT_EN
      if (i_abort && w_active) begin
         w_state_nxt = ST_DONE;
         w_found_nxt = 1'b0;
         w_issue     = 1'b0;
         w_flush     = 1'b1;
      end
`endif

      // Candidates are formed in W+1 bits so a range ending at all-ones
      // masks the overflowing lanes instead of wrapping to seed 0.
      if (w_issue) begin
         for (int i = 0; i < int'(LANES); i++) begin
            w_lane_seed_nxt[i*W +: W] = W'(w_issue_ptr + PW'(i));
            w_lane_valid_nxt[i]       = (w_issue_ptr + PW'(i)) <= PW'(w_issue_hi);
         end
         w_ptr_nxt = w_issue_ptr + PW'(LANES);
      end

      w_busy_nxt = (w_state_nxt == ST_SCAN) || (w_state_nxt == ST_DRAIN);
      w_done_nxt = (w_state_nxt == ST_DONE);
   end

   // State and output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_ptr        <= '0;
         r_seed_hi    <= '0;
         r_lane_seed  <= '0;
         r_lane_valid <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_found      <= 1'b0;
         r_found_seed <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_ptr        <= w_ptr_nxt;
         r_seed_hi    <= w_seed_hi_nxt;
         r_lane_seed  <= w_lane_seed_nxt;
         r_lane_valid <= w_lane_valid_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_found      <= w_found_nxt;
         r_found_seed <= w_found_seed_nxt;
      end
   end

   assign o_lane_seed  = r_lane_seed;
   assign o_lane_valid = r_lane_valid;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_found      = r_found;
   assign o_found_seed = r_found_seed;

endmodule
